// File: rtl/pixel_frame_store_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_frame_store_if
// Brief    : Bundle of scan-out, write-port, swap and clear signals between
//            the frame store and its users (pixel iterator, game logic).
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_frame_store_if #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int BPP        = 1,
  parameter int SCALE_LOG2 = 0
) ();
  localparam int XW  = $clog2(H_RES);
  localparam int YW  = $clog2(V_RES);
  localparam int WXW = $clog2(H_RES >> SCALE_LOG2);
  localparam int WYW = $clog2(V_RES >> SCALE_LOG2);

  logic           ce;
  // scan-out side
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic           de;
  logic           swap;
  logic [BPP-1:0] rd_data;
  logic           rd_de;
  // game-logic write side
  logic           wr_valid;
  logic           wr_ready;
  logic [WXW-1:0] wr_x;
  logic [WYW-1:0] wr_y;
  logic [BPP-1:0] wr_data;
  logic           swap_req;
  logic           swap_pending;
  logic           front;
  // clear engine
  logic           clear_start;
  logic [BPP-1:0] clear_fill;
  logic           clear_busy;

  modport master (
    output ce, x, y, de, swap, wr_valid, wr_x, wr_y, wr_data, swap_req,
           clear_start, clear_fill,
    input  rd_data, rd_de, wr_ready, swap_pending, front, clear_busy
  );

  modport slave (
    input  ce, x, y, de, swap, wr_valid, wr_x, wr_y, wr_data, swap_req,
           clear_start, clear_fill,
    output rd_data, rd_de, wr_ready, swap_pending, front, clear_busy
  );
endinterface
`default_nettype wire

// File: rtl/pixel_frame_store.sv
`default_nettype none
// ============================================================================
// Module   : pixel_frame_store
// Brief    : Double-buffered, downscaled frame store. Game logic writes the
//            back bank, scan-out reads the front bank with 2-cycle latency,
//            banks swap only on a vblank pulse after a request.
//            Optional back-bank clear engine: PIXEL_FRAME_STORE_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_frame_store #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int BPP        = 1,
  parameter int SCALE_LOG2 = 0
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pixel_frame_store_if.slave bus
);
  localparam int LW    = H_RES >> SCALE_LOG2;
  localparam int LH    = V_RES >> SCALE_LOG2;
  localparam int DEPTH = LW * LH;
  localparam int AW    = $clog2(DEPTH);
  localparam int WXW   = $clog2(LW);
  localparam int WYW   = $clog2(LH);

  typedef enum logic [0:0] {SW_IDLE = 1'b0, SW_PENDING = 1'b1} swap_state_t;

  logic [AW-1:0]  w_rd_addr;
  logic [AW-1:0]  r_rd_addr;
  logic           r_de_d1;
  logic           r_de_d2;
  logic           r_rd_bank;
  logic [AW-1:0]  w_wr_addr;
  logic           w_wr_in_range;
  logic           w_wr_fire;
  logic           w_we;
  logic [AW-1:0]  w_waddr;
  logic [BPP-1:0] w_wdata;
  logic           w_clear_busy;
  logic           r_front;
  logic           w_front_next;
  swap_state_t    r_swap_state;
  swap_state_t    w_swap_next;

  // Screen coordinates collapse onto the logical grid before addressing.
  assign w_rd_addr = AW'(bus.y >> SCALE_LOG2) * AW'(LW) + AW'(bus.x >> SCALE_LOG2);
  assign w_wr_addr = AW'(bus.wr_y) * AW'(LW) + AW'(bus.wr_x);
  assign w_wr_in_range = ({1'b0, bus.wr_x} < (WXW + 1)'(LW)) &&
                         ({1'b0, bus.wr_y} < (WYW + 1)'(LH));

  assign bus.wr_ready = bus.ce & ~w_clear_busy & ~rst;
  assign w_wr_fire    = bus.wr_valid & bus.wr_ready;

  // Read pipeline: stage 1 holds address/de, stage 2 aligns de and bank select with RAM output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_de_d1   <= 1'b0;
      r_de_d2   <= 1'b0;
      r_rd_bank <= 1'b0;
    end else if (bus.ce) begin
      r_rd_addr <= w_rd_addr;
      r_de_d1   <= bus.de;
      r_de_d2   <= r_de_d1;
      r_rd_bank <= r_front;
    end
  end

  // Both banks are read every cycle; the bank that was front at read time is selected.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [BPP-1:0] mem [DEPTH];
    logic [BPP-1:0] r_q;

    // Writes only ever land in the back bank.
    always_ff @(posedge clk) begin
      if (bus.ce) begin
        if (w_we && (r_front == (b == 0))) begin
          mem[w_waddr] <= w_wdata;
        end
        r_q <= mem[r_rd_addr];
      end
    end
  end

  assign bus.rd_de   = r_de_d2;
  assign bus.rd_data = r_de_d2 ? (r_rd_bank ? g_bank[1].r_q : g_bank[0].r_q) : '0;

  // Swap state and displayed-bank index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_swap_state <= SW_IDLE;
      r_front      <= 1'b0;
    end else if (bus.ce) begin
      r_swap_state <= w_swap_next;
      r_front      <= w_front_next;
    end
  end

  // A swap only completes on the vblank pulse and never while the back bank is being cleared.
  always_comb begin
    w_swap_next  = r_swap_state;
    w_front_next = r_front;
    case (r_swap_state)
      SW_IDLE: begin
        if (bus.swap_req) begin
          if (bus.swap && !w_clear_busy) begin
            w_front_next = ~r_front;
          end else begin
            w_swap_next = SW_PENDING;
          end
        end
      end
      SW_PENDING: begin
        if (bus.swap && !w_clear_busy) begin
          w_front_next = ~r_front;
          w_swap_next  = SW_IDLE;
        end
      end
      default: w_swap_next = SW_IDLE;
    endcase
  end

  assign bus.swap_pending = (r_swap_state == SW_PENDING);
  assign bus.front        = r_front;

`ifdef PIXEL_FRAME_STORE_CLEAR_EN
  typedef enum logic [0:0] {CL_IDLE = 1'b0, CL_CLEAR = 1'b1} clr_state_t;

  clr_state_t     r_clr_state;
  clr_state_t     w_clr_next;
  logic [AW-1:0]  r_clr_cnt;
  logic [AW-1:0]  w_clr_cnt_next;
  logic [BPP-1:0] r_clr_fill;
  logic [BPP-1:0] w_clr_fill_next;

  // Clear engine registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_state <= CL_IDLE;
      r_clr_cnt   <= '0;
      r_clr_fill  <= '0;
    end else if (bus.ce) begin
      r_clr_state <= w_clr_next;
      r_clr_cnt   <= w_clr_cnt_next;
      r_clr_fill  <= w_clr_fill_next;
    end
  end

  // Sweep the whole back bank one word per cycle with the colour captured at start.
  always_comb begin
    w_clr_next      = r_clr_state;
    w_clr_cnt_next  = r_clr_cnt;
    w_clr_fill_next = r_clr_fill;
    case (r_clr_state)
      CL_IDLE: begin
        if (bus.clear_start) begin
          w_clr_next      = CL_CLEAR;
          w_clr_cnt_next  = '0;
          w_clr_fill_next = bus.clear_fill;
        end
      end
      CL_CLEAR: begin
        if (r_clr_cnt == AW'(DEPTH - 1)) begin
          w_clr_next = CL_IDLE;
        end else begin
          w_clr_cnt_next = r_clr_cnt + 1'b1;
        end
      end
      default: w_clr_next = CL_IDLE;
    endcase
  end

  assign w_clear_busy = (r_clr_state == CL_CLEAR);

  // Back-bank write source: clear sweep has priority (the port is not ready meanwhile).
  always_comb begin
    w_we    = w_wr_fire & w_wr_in_range;
    w_waddr = w_wr_addr;
    w_wdata = bus.wr_data;
    if (w_clear_busy) begin
      w_we    = 1'b1;
      w_waddr = r_clr_cnt;
      w_wdata = r_clr_fill;
    end
  end
`else
  logic unused_clear;
  assign unused_clear = ^{bus.clear_start, bus.clear_fill};
  assign w_clear_busy = 1'b0;

  // Back-bank write source: game-logic port only.
  always_comb begin
    w_we    = w_wr_fire & w_wr_in_range;
    w_waddr = w_wr_addr;
    w_wdata = bus.wr_data;
  end
`endif

  assign bus.clear_busy = w_clear_busy;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_frame_store
// Brief    : Self-checking bench for pixel_frame_store (640x480, 2 bpp, x2).
//            Clear-engine checks are built when PIXEL_FRAME_STORE_CLEAR_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_frame_store;
  localparam int H_RES      = 640;
  localparam int V_RES      = 480;
  localparam int BPP        = 2;
  localparam int SCALE_LOG2 = 1;
  localparam int SC         = 1 << SCALE_LOG2;
  localparam int LW         = H_RES / SC;
  localparam int LH         = V_RES / SC;
  localparam int DEPTH      = LW * LH;
  localparam int XW         = $clog2(H_RES);
  localparam int YW         = $clog2(V_RES);
  localparam int WXW        = $clog2(LW);
  localparam int WYW        = $clog2(LH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: two banks of logical pixels plus which entries are defined.
  logic [BPP-1:0] mbank [2][DEPTH];
  bit             known [2][DEPTH];
  int             m_front   = 0;
  bit             m_pending = 1'b0;

  typedef struct {
    logic           de;
    bit             chk;
    logic [BPP-1:0] data;
  } rexp_t;
  rexp_t rq [$];

  pixel_frame_store_if #(.H_RES(H_RES), .V_RES(V_RES), .BPP(BPP), .SCALE_LOG2(SCALE_LOG2)) bus ();

  pixel_frame_store #(.H_RES(H_RES), .V_RES(V_RES), .BPP(BPP), .SCALE_LOG2(SCALE_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.ce          = 1'b1;
    bus.x           = '0;
    bus.y           = '0;
    bus.de          = 1'b0;
    bus.swap        = 1'b0;
    bus.swap_req    = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_x        = '0;
    bus.wr_y        = '0;
    bus.wr_data     = '0;
    bus.clear_start = 1'b0;
    bus.clear_fill  = '0;
  endtask

  function automatic int laddr(input int lx, input int ly);
    return ly * LW + lx;
  endfunction

  // One accepted write; lands in the back bank only when inside the logical grid.
  task automatic wr_one(input int wx, input int wy, input logic [BPP-1:0] d);
    bus.ce       = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_x     = WXW'(wx);
    bus.wr_y     = WYW'(wy);
    bus.wr_data  = d;
    #1;
    check("wr_ready", bus.wr_ready, 1);
    if (wx < LW && wy < LH) begin
      mbank[1 - m_front][laddr(wx, wy)] = d;
      known[1 - m_front][laddr(wx, wy)] = 1'b1;
    end
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic swap_now();
    bus.swap_req = 1'b1;
    bus.swap     = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    bus.swap     = 1'b0;
    m_front   = 1 - m_front;
    m_pending = 1'b0;
    check("swap_front", bus.front, m_front);
    check("swap_pending", bus.swap_pending, m_pending);
  endtask

  // Present one scan-out coordinate; compare outputs of the coordinate from two edges ago.
  task automatic read_cycle(input int sx, input int sy, input bit sde);
    rexp_t e;
    rexp_t o;
    int    a;
    bus.ce = 1'b1;
    bus.x  = XW'(sx);
    bus.y  = YW'(sy);
    bus.de = sde;
    a      = (sy / SC) * LW + (sx / SC);
    e.de   = sde;
    e.chk  = !sde || known[m_front][a];
    e.data = sde ? mbank[m_front][a] : '0;
    rq.push_back(e);
    tick();
    if (rq.size() >= 2) begin
      o = rq.pop_front();
      check("rd_de", bus.rd_de, o.de);
      if (o.chk) check("rd_data", bus.rd_data, o.data);
    end
  endtask

  task automatic read_flush();
    read_cycle(0, 0, 1'b0);
    rq.delete();
  endtask

  // Random write/swap traffic with random clock-enable, tracked by the model.
  task automatic rand_write_cycle();
    int             wx;
    int             wy;
    bit             ce_v;
    bit             val;
    bit             sreq;
    bit             sw;
    logic [BPP-1:0] d;
    ce_v = ($urandom_range(0, 7) != 0);
    val  = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 7) == 0) begin
      wx = LW + int'($urandom_range(0, (1 << WXW) - LW - 1));
    end else begin
      wx = int'($urandom_range(0, 15));
    end
    wy   = int'($urandom_range(0, 7));
    d    = BPP'($urandom);
    sreq = ($urandom_range(0, 9) == 0);
    sw   = ($urandom_range(0, 5) == 0);
    bus.ce       = ce_v;
    bus.wr_valid = val;
    bus.wr_x     = WXW'(wx);
    bus.wr_y     = WYW'(wy);
    bus.wr_data  = d;
    bus.swap_req = sreq;
    bus.swap     = sw;
    #1;
    check("wr_ready_ce", bus.wr_ready, ce_v);
    if (ce_v) begin
      if (val && wx < LW && wy < LH) begin
        mbank[1 - m_front][laddr(wx, wy)] = d;
        known[1 - m_front][laddr(wx, wy)] = 1'b1;
      end
      if (m_pending) begin
        if (sw) begin
          m_front   = 1 - m_front;
          m_pending = 1'b0;
        end
      end else if (sreq) begin
        if (sw) m_front = 1 - m_front;
        else    m_pending = 1'b1;
      end
    end
    tick();
    check("rand_front", bus.front, m_front);
    check("rand_pending", bus.swap_pending, m_pending);
  endtask

  initial begin
    int             cnt;
    int             f0;
    logic [BPP-1:0] v;

    drive_idle();
    bus.ce = 1'b0;
    rst    = 1'b1;
    repeat (3) tick();
    // reset state
    check("rst_front", bus.front, 0);
    check("rst_pending", bus.swap_pending, 0);
    check("rst_rd_de", bus.rd_de, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_clear_busy", bus.clear_busy, 0);
    bus.ce = 1'b1;
    #1;
    check("rst_wr_ready", bus.wr_ready, 0);
    rst = 1'b0;
    #1;
    check("wr_ready_after_rst", bus.wr_ready, 1);
    tick();

    // directed write, request, vblank swap, scan the upscaled 2x2 block
    wr_one(10, 20, 2'b11);
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    m_pending = 1'b1;
    check("req_pending", bus.swap_pending, 1);
    check("req_front", bus.front, 0);
    bus.swap = 1'b1;
    tick();
    bus.swap = 1'b0;
    m_front   = 1;
    m_pending = 1'b0;
    check("vblank_front", bus.front, 1);
    check("vblank_pending", bus.swap_pending, 0);
    for (int yy = 40; yy <= 41; yy++) begin
      for (int xx = 20; xx <= 21; xx++) begin
        read_cycle(xx, yy, 1'b1);
      end
    end
    read_flush();

    // fill a 16x8 logical region of both banks so later reads are defined
    for (int k = 0; k < 2; k++) begin
      for (int wy = 0; wy < 8; wy++) begin
        for (int wx = 0; wx < 16; wx++) begin
          wr_one(wx, wy, BPP'($urandom));
        end
      end
      swap_now();
    end
    for (int i = 0; i < 64; i++) begin
      read_cycle(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), 1'b1);
    end
    read_flush();

    // out-of-range write must not alias onto (0,6)
    wr_one(0, 6, 2'b10);
    wr_one(320, 5, 2'b01);
    swap_now();
    for (int yy = 12; yy <= 13; yy++) begin
      for (int xx = 0; xx <= 1; xx++) begin
        read_cycle(xx, yy, 1'b1);
      end
    end
    read_flush();
    check("oor_model_cell", mbank[m_front][laddr(0, 6)], 2'b10);

    // long pending without a vblank pulse
    f0 = m_front;
    bus.swap_req = 1'b1;
    tick();
    m_pending = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus.swap_req = ($urandom_range(0, 1) == 1);
      tick();
      if (i % 250 == 249) begin
        check("hold_pending", bus.swap_pending, 1);
        check("hold_front", bus.front, f0);
      end
    end
    bus.swap_req = 1'b0;
    bus.swap     = 1'b1;
    tick();
    bus.swap  = 1'b0;
    m_front   = 1 - m_front;
    m_pending = 1'b0;
    check("late_swap_front", bus.front, m_front);
    check("late_swap_pending", bus.swap_pending, 0);
    swap_now();
    // lone vblank while idle is ignored
    bus.swap = 1'b1;
    tick();
    bus.swap = 1'b0;
    check("idle_swap_front", bus.front, m_front);
    check("idle_swap_pending", bus.swap_pending, 0);

    // clock enable low freezes pipeline, swap state and write port
    bus.x  = XW'(6);
    bus.y  = YW'(8);
    bus.de = 1'b1;
    tick();
    bus.de = 1'b0;
    bus.x  = XW'(30);
    tick();
    v = mbank[m_front][laddr(3, 4)];
    check("ce_pre_rd_de", bus.rd_de, 1);
    check("ce_pre_rd_data", bus.rd_data, v);
    bus.ce       = 1'b0;
    bus.swap_req = 1'b1;
    bus.swap     = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_x     = WXW'(3);
    bus.wr_y     = WYW'(4);
    bus.wr_data  = ~mbank[1 - m_front][laddr(3, 4)];
    #1;
    check("ce_wr_ready", bus.wr_ready, 0);
    repeat (3) tick();
    check("ce_hold_rd_de", bus.rd_de, 1);
    check("ce_hold_rd_data", bus.rd_data, v);
    check("ce_hold_front", bus.front, m_front);
    check("ce_hold_pending", bus.swap_pending, 0);
    drive_idle();
    tick();
    tick();

    // randomized traffic alternating write/swap bursts with scan-out bursts
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < 40; i++) rand_write_cycle();
      drive_idle();
      for (int i = 0; i < 48; i++) begin
        read_cycle(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                   $urandom_range(0, 3) != 0);
      end
      read_flush();
    end
    if (m_pending) begin
      bus.swap = 1'b1;
      tick();
      bus.swap  = 1'b0;
      m_front   = 1 - m_front;
      m_pending = 1'b0;
      check("drain_front", bus.front, m_front);
    end

`ifdef PIXEL_FRAME_STORE_CLEAR_EN
    // clear with fill 1, swap pending across it, ten clock-enable-low cycles inside
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    m_pending = 1'b1;
    check("clr_pre_pending", bus.swap_pending, 1);
    f0 = m_front;
    bus.clear_fill  = 2'd1;
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    bus.clear_fill  = 2'd2;
    check("clr_busy_rise", bus.clear_busy, 1);
    cnt = 0;
    while (bus.clear_busy === 1'b1 && cnt < 80000) begin
      bus.ce          = !(cnt >= 500 && cnt < 510);
      bus.clear_start = (cnt == 100);
      bus.swap        = (cnt % 1000 == 7);
      bus.wr_valid    = 1'b1;
      bus.wr_x        = WXW'($urandom_range(0, 15));
      bus.wr_y        = WYW'($urandom_range(0, 7));
      bus.wr_data     = 2'd3;
      #1;
      check("clr_wr_ready", bus.wr_ready, 0);
      tick();
      cnt++;
    end
    drive_idle();
    check("clr_cycles", cnt, DEPTH + 10);
    check("clr_front_held", bus.front, f0);
    check("clr_pending_held", bus.swap_pending, 1);
    for (int a = 0; a < DEPTH; a++) begin
      mbank[1 - m_front][a] = 2'd1;
      known[1 - m_front][a] = 1'b1;
    end
    bus.swap = 1'b1;
    tick();
    bus.swap  = 1'b0;
    m_front   = 1 - m_front;
    m_pending = 1'b0;
    check("clr_swap_front", bus.front, m_front);
    for (int i = 0; i < 300; i++) begin
      read_cycle(int'($urandom_range(0, H_RES - 1)), int'($urandom_range(0, V_RES - 1)), 1'b1);
    end
    read_flush();

    // reset in the middle of a clear with a swap pending
    if (m_front == 0) swap_now();
    bus.clear_fill  = 2'd2;
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    bus.swap_req    = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    check("mid_clr_pending", bus.swap_pending, 1);
    repeat (498) tick();
    check("mid_clr_busy", bus.clear_busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", bus.clear_busy, 0);
    check("abort_front", bus.front, 0);
    check("abort_pending", bus.swap_pending, 0);
    check("abort_wr_ready", bus.wr_ready, 0);
    tick();
    rst = 1'b0;
    m_front   = 0;
    m_pending = 1'b0;
    #1;
    check("abort_wr_ready_rel", bus.wr_ready, 1);
    tick();
    check("abort_busy_after", bus.clear_busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pixel_frame_store.md
# pixel_frame_store

Parametrised double-buffered frame store between game-logic writers and the video scan-out path. Holds two banks of logical pixels (BPP bits each, screen downscaled by 2^SCALE_LOG2 per axis); game logic writes the back bank through a valid/ready port while the pixel iterator reads the front bank with screen coordinates. Banks swap only on the iterator's vblank `swap` pulse after a swap request, so frames never tear. Optional hardware clear engine fills the back bank with a constant colour.

## Interface
- H_RES, 640, screen active width in pixels
- V_RES, 480, screen active height in pixels
- BPP, 1, bits per stored pixel (1..8)
- SCALE_LOG2, 0, log2 of integer upscale; logical grid is (H_RES>>SCALE_LOG2) x (V_RES>>SCALE_LOG2); DEPTH = product
- clk  in  1  pixel clock (clk_rgb domain); one clock only
- rst  in  1  reset, asynchronous, active-high
- ce  in  1  clock enable; low freezes all state and outputs
- x  in  $clog2(H_RES)  scan-out screen x
- y  in  $clog2(V_RES)  scan-out screen y
- de  in  1  scan-out data enable
- swap  in  1  vblank pulse from pixel iterator
- rd_data  out  BPP  front-bank pixel for (x,y), 2 cycles late
- rd_de  out  1  de delayed to align with rd_data
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_x  in  $clog2(H_RES>>SCALE_LOG2)  logical x
- wr_y  in  $clog2(V_RES>>SCALE_LOG2)  logical y
- wr_data  in  BPP  pixel value
- swap_req  in  1  request swap at next `swap` pulse
- swap_pending  out  1  request latched, swap not yet done
- front  out  1  index of bank being displayed
- clear_start  in  1  start back-bank clear (macro only)
- clear_fill  in  BPP  clear colour, sampled at clear_start
- clear_busy  out  1  clear in progress

## Operation
- Read address = (y>>SCALE_LOG2)*(H_RES>>SCALE_LOG2) + (x>>SCALE_LOG2), computed in $clog2(DEPTH) bits; read from bank `front`. Address computed regardless of de; rd_data driven 0 when delayed de is 0.
- Write address = wr_y*(H_RES>>SCALE_LOG2)+wr_x into bank ~front. Coordinates outside the logical grid: handshake completes, no RAM write.
- wr_ready = ce & ~clear_busy.
- Swap FSM, states IDLE/PENDING: IDLE -> PENDING on swap_req; PENDING -> IDLE on swap & ~clear_busy, toggling `front`. swap_req & swap in same cycle while IDLE with no clear: swap immediately. swap_req while PENDING: no effect. swap while IDLE: ignored.
- Clear FSM, states IDLE/CLEAR: clear_start in IDLE latches clear_fill, counter = 0, -> CLEAR. CLEAR writes fill to back bank at counter, one word per cycle; at counter = DEPTH-1 write last word, -> IDLE. clear_start while CLEAR ignored. Clear always targets bank ~front at start; swap is blocked during clear so target cannot change.
- ce low: no counters, FSMs, pipeline stages or RAM writes advance.

## Timing
- Reset values: rd_data 0, rd_de 0, wr_ready 0 during reset then ce-dependent, swap_pending 0, front 0, clear_busy 0. Bank contents undefined after reset.
- Read latency 2 cycles: cycle 0 register address and de; cycle 1 synchronous RAM read; rd_data/rd_de valid at cycle 2.
- Write takes effect at the accepting edge; readable from that bank once it becomes front.
- Write accepted in the same cycle `front` toggles lands in the old back bank (now front).
- Clear takes exactly DEPTH cycles; clear_busy high from the edge after clear_start to the edge after the last word.
- Reset mid-clear or mid-pending: abort, all state to reset values.

## Configuration
- PIXEL_FRAME_STORE_CLEAR_EN defined: clear engine present as described.
- Undefined: clear_start and clear_fill ignored, clear_busy tied 0, no clear counter; swap gating on clear_busy disappears.

## Test plan
- Reset, H_RES=640 V_RES=480 BPP=2 SCALE_LOG2=1: front=0, swap_pending=0, rd_de=0, rd_data=0, wr_ready=1 once ce=1.
- Write (10,20)=2'b11 to back bank, swap_req, then swap pulse: front=1; scanning screen (20..21, 40..41) gives rd_data=3 two cycles after each x,y, rd_de aligned.
- swap_req without swap for 1000 cycles: swap_pending=1, front unchanged; swap_req & swap together from IDLE: front toggles next edge.
- Write to wr_x=320, wr_y=5 (out of range): ready handshake completes, no bank location changes.
- With PIXEL_FRAME_STORE_CLEAR_EN, clear_fill=1: clear_busy high exactly 76800 cycles, wr_ready=0 throughout; swap pulse during clear deferred to first swap after clear_busy falls; whole back bank reads 1 after swap.
- Assert rst at clear cycle 500: clear_busy=0, front=0 immediately; ce=0 for 10 cycles mid-clear stretches clear to 76810 cycles.
